// File: rtl/riscv_dualport_slave.sv
// -----------------------------------------------------------------------------
// riscv_dualport_slave
//   Dual-port 32-bit word RAM that acts as the responder for the core's two bus
//   masters: port A serves instruction fetch, port B serves load/store traffic.
//   Each port has its own req/gnt/rvalid FSM with a fixed number of wait cycles,
//   so both pipeline stages see non-zero bus latency. Neither port can stall the
//   other.
//
// Parameters
//   AW         word-address width, depth = 2**AW words
//   WAIT_A     wait cycles between accept and response on port A (0..15)
//   WAIT_B     wait cycles between accept and response on port B (0..15)
//   INIT_FILE  name of a hex memory image for the array (empty = none)
//
// Ports (x = a | b)
//   clk            rising-edge clock
//   rst            synchronous active-high reset (RAM contents are kept)
//   i_x_req        request; accepted when i_x_req & o_x_gnt at a rising edge
//   i_x_we         1 = write, 0 = read
//   i_x_be         byte enables for writes
//   i_x_addr       byte address; word index = addr[AW+1:2]
//   i_x_wdata      write data
//   o_x_gnt        high only while the port FSM is idle
//   o_x_rvalid     one-cycle response strobe (reads and writes)
//   o_x_rdata      read data, zero outside the response cycle and for writes
//   o_x_err        address-range error, only with RISCV_DPSLAVE_ERR_EN
//
// Build option
//   RISCV_DPSLAVE_ERR_EN  when defined, addresses with any bit above AW+1 set
//                         are rejected: writes are dropped, reads return zero
//                         and o_x_err is raised together with o_x_rvalid.
//                         When undefined the high address bits alias.
// -----------------------------------------------------------------------------
module riscv_dualport_slave #(
  parameter int AW        = 10,
  parameter int WAIT_A    = 1,
  parameter int WAIT_B    = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_a_req,
  input  logic        i_a_we,
  input  logic [3:0]  i_a_be,
  input  logic [31:0] i_a_addr,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_gnt,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [3:0]  i_b_be,
  input  logic [31:0] i_b_addr,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_gnt,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rdata
`ifdef RISCV_DPSLAVE_ERR_EN
  ,
  output logic        o_a_err,
  output logic        o_b_err
`endif
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word storage; deliberately has no reset.
  logic [31:0] mem_q [DEPTH];

  // Both ports are folded into index-0 (A) / index-1 (B) vectors so that the
  // FSM is written once and the write-priority order is a simple loop order.
  logic [1:0]          req_s;
  logic [1:0]          we_s;
  logic [1:0][3:0]     be_s;
  logic [1:0][31:0]    addr_s;
  logic [1:0][31:0]    wdata_s;
  logic [1:0][AW-1:0]  idx_s;
  logic [1:0]          accept_s;
  logic [1:0]          bad_s;
  logic [1:0]          gnt_s;
  logic [1:0]          rvalid_s;
  logic [1:0]          err_s;
  logic [1:0][31:0]    rdata_s;

  assign req_s   = {i_b_req, i_a_req};
  assign we_s    = {i_b_we, i_a_we};
  assign be_s    = {i_b_be, i_a_be};
  assign addr_s  = {i_b_addr, i_a_addr};
  assign wdata_s = {i_b_wdata, i_a_wdata};

  // Byte-lane bits and (without the range check) the high address bits are
  // intentionally ignored; the image name is consumed by the memory-init flow.
  logic unused_addr_s;
  assign unused_addr_s = ^{addr_s[0][1:0], addr_s[0][31:AW+2],
                           addr_s[1][1:0], addr_s[1][31:AW+2], INIT_FILE != ""};

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam logic [3:0] WAIT_P = (p == 0) ? 4'(WAIT_A) : 4'(WAIT_B);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        err_q, err_d;

    assign idx_s[p]    = addr_s[p][AW+1:2];
    // Reset blocks acceptance so no array write can happen while rst is high.
    assign accept_s[p] = ~rst & req_s[p] & (state_q == ST_IDLE);

`ifdef RISCV_DPSLAVE_ERR_EN
    assign bad_s[p] = |addr_s[p][31:AW+2];
`else
    assign bad_s[p] = 1'b0;
`endif

    // Next-state, wait counter and read-capture logic for this port.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      err_d   = err_q;
      case (state_q)
        ST_IDLE: begin
          if (accept_s[p]) begin
            err_d = bad_s[p];
            // Read captures the pre-write word; writes respond with zero.
            if (we_s[p] || bad_s[p]) begin
              hold_d = 32'h0000_0000;
            end else begin
              hold_d = mem_q[idx_s[p]];
            end
            if (WAIT_P == 4'd0) begin
              state_d = ST_RESP;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_P - 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
          hold_d  = 32'h0000_0000;
          err_d   = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          hold_d  = 32'h0000_0000;
          err_d   = 1'b0;
        end
      endcase
    end

    // Port FSM state, wait counter and response hold registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        hold_q  <= 32'h0000_0000;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        err_q   <= err_d;
      end
    end

    assign gnt_s[p]    = (state_q == ST_IDLE);
    assign rvalid_s[p] = (state_q == ST_RESP);
    assign rdata_s[p]  = (state_q == ST_RESP) ? hold_q : 32'h0000_0000;
    assign err_s[p]    = (state_q == ST_RESP) & err_q;
  end

  // Byte-wise array writes; port B is applied last so its enabled bytes win a
  // same-word collision while A-only bytes still land.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (accept_s[p] && we_s[p] && !bad_s[p] && be_s[p][b]) begin
          mem_q[idx_s[p]][8*b +: 8] <= wdata_s[p][8*b +: 8];
        end
      end
    end
  end

  assign o_a_gnt    = gnt_s[0];
  assign o_a_rvalid = rvalid_s[0];
  assign o_a_rdata  = rdata_s[0];
  assign o_b_gnt    = gnt_s[1];
  assign o_b_rvalid = rvalid_s[1];
  assign o_b_rdata  = rdata_s[1];

`ifdef RISCV_DPSLAVE_ERR_EN
  assign o_a_err = err_s[0];
  assign o_b_err = err_s[1];
`else
  logic unused_err_s;
  assign unused_err_s = ^err_s;
`endif

endmodule

// File: tb/tb_riscv_dualport_slave.sv
// -----------------------------------------------------------------------------
// tb_riscv_dualport_slave
//   Self-checking bench for riscv_dualport_slave. A word-array reference model
//   tracks the RAM; expected read data, latencies and response spacing come
//   from the model and the configured wait counts.
// -----------------------------------------------------------------------------
module tb_riscv_dualport_slave;

  localparam int AW = 10;
  localparam int WA = 1;
  localparam int WB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we  = 2'b00;
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  int total = 0;
  int bad   = 0;

  bit [31:0] mdl [1 << AW];

  always #5 clk = ~clk;

  riscv_dualport_slave #(.AW(AW), .WAIT_A(WA), .WAIT_B(WB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_a_req    (req[0]),
    .i_a_we     (we[0]),
    .i_a_be     (be[0]),
    .i_a_addr   (addr[0]),
    .i_a_wdata  (wdata[0]),
    .o_a_gnt    (gnt[0]),
    .o_a_rvalid (rvalid[0]),
    .o_a_rdata  (rdata[0]),
    .i_b_req    (req[1]),
    .i_b_we     (we[1]),
    .i_b_be     (be[1]),
    .i_b_addr   (addr[1]),
    .i_b_wdata  (wdata[1]),
    .o_b_gnt    (gnt[1]),
    .o_b_rvalid (rvalid[1]),
    .o_b_rdata  (rdata[1])
`ifdef RISCV_DPSLAVE_ERR_EN
    ,
    .o_a_err    (err[0]),
    .o_b_err    (err[1])
`endif
  );

`ifndef RISCV_DPSLAVE_ERR_EN
  assign err = 2'b00;
`endif

  function automatic int waitp(input int p);
    return (p == 0) ? WA : WB;
  endfunction

  function automatic bit is_bad(input logic [31:0] ad);
`ifdef RISCV_DPSLAVE_ERR_EN
    return |ad[31:AW+2];
`else
    return 1'b0;
`endif
  endfunction

  // Reference model write: byte lanes per enable, out-of-range dropped.
  task automatic mwrite(input logic [31:0] ad, input logic [3:0] b, input logic [31:0] wd);
    if (!is_bad(ad)) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mdl[ad[AW+1:2]][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  // One transaction on port p; called and returns at a falling edge.
  task automatic txn(input int p, input bit w, input logic [3:0] b, input logic [31:0] ad,
                     input logic [31:0] wd, output logic [31:0] rd, output logic ef);
    int n;
    n = 0;
    while (gnt[p] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    req[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = ad; wdata[p] = wd;
    @(negedge clk);
    // Post-accept changes must be ignored.
    req[p] = 1'b0; we[p] = 1'($urandom); be[p] = 4'($urandom);
    addr[p] = $urandom; wdata[p] = $urandom;
    n = 1;
    while (rvalid[p] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != waitp(p) + 1) begin
      bad++;
      $display("FAIL latency port%0d: got %0d cycles, want %0d", p, n, waitp(p) + 1);
    end
    rd = rdata[p];
    ef = err[p];
    @(negedge clk);
    total++;
    if (rvalid[p] !== 1'b0 || gnt[p] !== 1'b1 || rdata[p] !== 32'h0) begin
      bad++;
      $display("FAIL idle_after_resp port%0d: rvalid=%b gnt=%b rdata=%h, want 0 1 00000000",
               p, rvalid[p], gnt[p], rdata[p]);
    end
  endtask

  task automatic test_reset;
    bit seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (gnt[p] !== 1'b1 || rvalid[p] !== 1'b0 || rdata[p] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state port%0d: gnt=%b rvalid=%b rdata=%h, want 1 0 00000000",
                 p, gnt[p], rvalid[p], rdata[p]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0000_0100;
    @(negedge clk);
    req[1] = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid[1] !== 1'b0) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[1] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_drop: o_b_rvalid seen after mid-read reset, want none");
    end
    total++;
    if (gnt[1] !== 1'b1 || rdata[1] !== 32'h0) begin
      bad++;
      $display("FAIL reset_after: gnt=%b rdata=%h, want 1 00000000", gnt[1], rdata[1]);
    end
  endtask

  task automatic test_spec_vectors;
    logic [31:0] rd, rd2;
    logic e, e2;
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, rd, e);
    mwrite(32'h10, 4'hF, 32'hDEAD_BEEF);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("FAIL write_rdata: got %h want 00000000", rd);
    end
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, e);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL a_readback: got %h want deadbeef", rd);
    end
    txn(1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, rd, e);
    txn(1, 1'b1, 4'h1, 32'h20, 32'h0000_00AA, rd, e);
    mwrite(32'h20, 4'hF, 32'h1122_3344);
    mwrite(32'h20, 4'h1, 32'h0000_00AA);
    txn(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, e);
    total++;
    if (rd !== 32'h1122_33AA) begin
      bad++; $display("FAIL b_byte_write: got %h want 112233aa", rd);
    end
    fork
      txn(0, 1'b1, 4'hF, 32'h40, 32'h1111_1111, rd, e);
      txn(1, 1'b1, 4'h3, 32'h40, 32'h2222_2222, rd2, e2);
    join
    mwrite(32'h40, 4'hF, 32'h1111_1111);
    mwrite(32'h40, 4'h3, 32'h2222_2222);
    txn(0, 1'b0, 4'hF, 32'h40, 32'h0, rd, e);
    total++;
    if (rd !== 32'h1111_2222) begin
      bad++; $display("FAIL ww_collision: got %h want 11112222", rd);
    end
    txn(1, 1'b1, 4'hF, 32'h44, 32'hCAFE_F00D, rd, e);
    fork
      txn(0, 1'b0, 4'hF, 32'h44, 32'h0, rd, e);
      txn(1, 1'b1, 4'hF, 32'h44, 32'h0BAD_C0DE, rd2, e2);
    join
    mwrite(32'h44, 4'hF, 32'h0BAD_C0DE);
    total++;
    if (rd !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL rw_collision_old: got %h want cafef00d", rd);
    end
    txn(1, 1'b0, 4'hF, 32'h44, 32'h0, rd, e);
    total++;
    if (rd !== 32'h0BAD_C0DE) begin
      bad++; $display("FAIL rw_collision_new: got %h want 0badc0de", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic e;
    int issued, got, last, cyc;
    bit overlap;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = $urandom;
      txn(0, 1'b1, 4'hF, 32'(i * 4), v, rd, e);
      mwrite(32'(i * 4), 4'hF, v);
    end
    issued = 0; got = 0; last = -1; cyc = 0; overlap = 1'b0;
    while (got < 3 && cyc < 60) begin
      if (rvalid[0] === 1'b1) begin
        total++;
        if (rdata[0] !== mdl[got]) begin
          bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, rdata[0], mdl[got]);
        end
        if (last >= 0) begin
          total++;
          if (cyc - last != WA + 2) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc - last, WA + 2);
          end
        end
        last = cyc;
        got++;
      end
      if (gnt[0] === 1'b1 && rvalid[0] === 1'b1) overlap = 1'b1;
      if (gnt[0] === 1'b1) begin
        if (issued < 3) begin
          req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'(issued * 4);
          issued++;
        end else begin
          req[0] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req[0] = 1'b0;
    @(negedge clk);
    total++;
    if (got != 3 || overlap) begin
      bad++; $display("FAIL b2b_count: responses=%0d overlap=%0d want 3 0", got, overlap);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, ad;
    logic e;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      ad = $urandom;
      ad[AW+1:2] = AW'(i);
`ifdef RISCV_DPSLAVE_ERR_EN
      ad[31:AW+2] = '0;
`endif
      txn(0, 1'b1, 4'hF, ad, v, rd, e);
      mwrite(ad, 4'hF, v);
    end
    for (int it = 0; it < 40; it++) begin
      bit          act [2];
      bit          w   [2];
      logic [3:0]  b   [2];
      logic [31:0] a   [2];
      logic [31:0] wd  [2];
      logic [31:0] r   [2];
      logic [31:0] ex  [2];
      logic        ef  [2];
      for (int p = 0; p < 2; p++) begin
        act[p] = ($urandom_range(0, 3) != 0);
        w[p]   = 1'($urandom);
        b[p]   = 4'($urandom);
        wd[p]  = $urandom;
        a[p]   = $urandom;
        a[p][AW+1:2] = AW'($urandom_range(0, 15));
`ifdef RISCV_DPSLAVE_ERR_EN
        a[p][31:AW+2] = '0;
`endif
        ex[p] = w[p] ? 32'h0 : mdl[a[p][AW+1:2]];
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p] && w[p]) mwrite(a[p], b[p], wd[p]);
      end
      fork
        begin if (act[0]) txn(0, w[0], b[0], a[0], wd[0], r[0], ef[0]); end
        begin if (act[1]) txn(1, w[1], b[1], a[1], wd[1], r[1], ef[1]); end
      join
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          total++;
          if (r[p] !== ex[p] || ef[p] !== 1'b0) begin
            bad++;
            $display("FAIL random it%0d port%0d we=%0d addr=%h: rdata=%h err=%b want %h 0",
                     it, p, w[p], a[p], r[p], ef[p], ex[p]);
          end
        end
      end
    end
  endtask

  task automatic test_err;
    logic [31:0] rd, hi;
    logic e;
    hi = 32'(1) << (AW + 2);
`ifdef RISCV_DPSLAVE_ERR_EN
    txn(1, 1'b0, 4'hF, hi, 32'h0, rd, e);
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL err_read: err=%b rdata=%h want 1 00000000", e, rd);
    end
    txn(1, 1'b1, 4'hF, hi, 32'hFFFF_FFFF, rd, e);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL err_write: err=%b want 1", e);
    end
    txn(0, 1'b0, 4'hF, 32'h0, 32'h0, rd, e);
    total++;
    if (rd !== mdl[0] || e !== 1'b0) begin
      bad++; $display("FAIL err_nowrite: word0=%h err=%b want %h 0", rd, e, mdl[0]);
    end
`else
    txn(1, 1'b1, 4'hF, hi, 32'h5A5A_5A5A, rd, e);
    mwrite(hi, 4'hF, 32'h5A5A_5A5A);
    txn(0, 1'b0, 4'hF, 32'h0, 32'h0, rd, e);
    total++;
    if (rd !== 32'h5A5A_5A5A) begin
      bad++; $display("FAIL alias_word0: got %h want 5a5a5a5a", rd);
    end
`endif
  endtask

  initial begin
    be[0] = 4'h0; be[1] = 4'h0;
    addr[0] = 32'h0; addr[1] = 32'h0;
    wdata[0] = 32'h0; wdata[1] = 32'h0;
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_random();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
